dcache_wt: RTL
==============

Name: dcache_wt

Overview:
- Direct-mapped, write-through, write-no-allocate data cache. It sits between the CPU data port and the data-side port of the shared block memory.
- The memory answers a read with a 4-word block, {word0,word1,word2,word3}, on a 64-bit bus, one cycle after it samples the read. It writes one word per clocked write, taken from data[15:0].
- The cache is the initiator on that bus. It generates block-aligned fills and single-word write-throughs, and serves the CPU with a request/ready handshake.

Parameters:
- WORD_SIZE, 16, CPU word and address width.
- BANDWIDTH, 64, memory data bus width (4 words).
- NUM_LINES, 4, number of cache lines (power of 2).
- MEM_LATENCY, 2, cycles m_readM is held before the block on m_data is captured (minimum 2).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- c_read  in  1  CPU read request, held until c_ready.
- c_write  in  1  CPU write request, held until c_ready.
- c_address  in  16  CPU word address.
- c_wdata  in  16  CPU write data.
- c_rdata  out  16  read data, valid while c_ready=1 on a read.
- c_ready  out  1  one-cycle completion pulse.
- m_readM  out  1  memory block read.
- m_writeM  out  1  memory word write.
- m_address  out  16  memory address.
- m_data  inout  64  memory data; driven only in WRITE, else high-Z.
- hit_count  out  16  read hits since reset.
- miss_count  out  16  read misses since reset.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE; all valid bits cleared; latency counter=0.
  - c_ready, c_rdata, m_readM, m_writeM, m_address, hit_count and miss_count all 0; m_data high-Z.
- Address split:
  - offset = addr[1:0].
  - index = addr[log2(NUM_LINES)+1:2].
  - tag = remaining upper bits.
  - Word k of a line/block occupies bits [63-16k : 48-16k], so word0 is in the MSBs.
- States: IDLE, FILL, WRITE, RESP.
- IDLE:
  - Samples requests at posedge. If c_write and c_read are both high, c_write wins.
  - c_write → WRITE, with m_address=c_address and m_writeM=1 registered.
  - c_read hit (valid && tag match) → RESP; c_rdata=selected word; hit_count+1.
  - c_read miss → FILL; m_readM=1; m_address={c_address[15:2],2'b00}; counter=1; miss_count+1.
- FILL:
  - m_readM is held high for MEM_LATENCY cycles.
  - At the posedge ending the last cycle: capture m_data into the line, write tag, set valid, load c_rdata with the offset word, drop m_readM → RESP.
- WRITE:
  - Lasts exactly 1 cycle with m_writeM=1 and m_data={48'b0, c_wdata}; the memory writes at the closing posedge.
  - On a hit, the cached word at the offset is updated in the same posedge.
  - On a miss, there is no allocate: valid/tag are unchanged.
  - Then m_writeM=0 and m_data is released → RESP.
- RESP:
  - c_ready=1 for exactly one cycle → IDLE.
  - The request present during RESP is treated as completed; a new request is sampled the cycle after RESP.
- Latency from the request being sampled to c_ready: read hit 1 cycle; read miss MEM_LATENCY+1 cycles; write 2 cycles.
- c_rdata holds its last value outside RESP.
- Counters saturate at 0xFFFF; no wrap.
- Requests that drop before c_ready are protocol violations; the operation still completes.
- m_readM and m_writeM are never high together.

Test Plan:
- Reset, memory words 0x24..0x27 = f01c,6100,f41c,6200; read 0x0025 → m_readM high 2 cycles with m_address=0x0024, c_ready 3 cycles after sampling, c_rdata=0x6100, miss_count=1.
- Then read 0x0026 → no m_readM, c_ready next cycle, c_rdata=0xF41C, hit_count=1.
- Write 0x0026 data 0xABCD → m_writeM 1 cycle, m_address=0x0026, m_data=0x000000000000ABCD, c_ready 2 cycles after sampling; then read 0x0026 hit returns 0xABCD and memory word 0x26=0xABCD.
- Write miss 0x0040 data 0x1234 → memory updated, no fill; next read 0x0040 misses and returns 0x1234.
- Conflict (NUM_LINES=4): reads 0x0024, 0x0034, 0x0024 → three misses (miss_count=3), three fills at 0x0024, 0x0034, 0x0024.
- Assert reset during FILL cycle 1 → m_readM=0 with no clock edge; after release, read 0x0024 misses again, and hit_count and miss_count restart from 0.

Source files
------------

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, write-no-allocate data cache.
// It sits between the CPU data port and the data-side port of the shared
// block memory.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   c_read / c_write      CPU requests, held until c_ready (write wins if both)
//   c_address, c_wdata    CPU word address and write data
//   c_rdata               read data, valid while c_ready=1 on a read; holds otherwise
//   c_ready               one-cycle completion pulse
//   m_readM / m_writeM    memory block read / single-word write strobes
//   m_address             memory address (block-aligned for fills)
//   m_data                64-bit memory bus; driven only while writing, else high-Z
//   hit_count, miss_count saturating read hit / miss counters
module dcache_wt #(
    parameter int WORD_SIZE   = 16,
    parameter int BANDWIDTH   = 64,
    parameter int NUM_LINES   = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_read,
    input  logic                 c_write,
    input  logic [WORD_SIZE-1:0] c_address,
    input  logic [WORD_SIZE-1:0] c_wdata,
    output logic [WORD_SIZE-1:0] c_rdata,
    output logic                 c_ready,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    inout  wire  [BANDWIDTH-1:0] m_data,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    localparam int WORDS = BANDWIDTH / WORD_SIZE;
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } state_t;

    state_t state, state_next;

    // Line storage; word 0 of a line is the most significant word of the bus.
    logic [WORD_SIZE-1:0] line_data [NUM_LINES][WORDS];
    logic [TAG_W-1:0]     line_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] line_valid;

    // Request held for the duration of an operation. The word offset is kept
    // separately because m_address is block-aligned during a fill.
    logic [OFF_W-1:0]     off_q, off_next;
    logic [WORD_SIZE-1:0] wdata_q, wdata_next;
    logic [CNT_W-1:0]     cnt, cnt_next;

    logic                 readm_next, writem_next;
    logic [WORD_SIZE-1:0] addr_next, rdata_next;
    logic [15:0]          hit_next, miss_next;
    logic                 fill_en, wr_hit_en;

    // Incoming request fields
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_hit;

    // Fields of the operation in progress (taken from m_address)
    logic [IDX_W-1:0] cur_idx;
    logic [TAG_W-1:0] cur_tag;
    logic             cur_hit;

    logic [WORD_SIZE-1:0] bus_word [WORDS];

    assign req_off = c_address[OFF_W-1:0];
    assign req_idx = c_address[IDX_W+OFF_W-1:OFF_W];
    assign req_tag = c_address[WORD_SIZE-1 -: TAG_W];
    assign req_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    assign cur_idx = m_address[IDX_W+OFF_W-1:OFF_W];
    assign cur_tag = m_address[WORD_SIZE-1 -: TAG_W];
    assign cur_hit = line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);

    for (genvar k = 0; k < WORDS; k++) begin : g_split
        assign bus_word[k] = m_data[BANDWIDTH-1-WORD_SIZE*k -: WORD_SIZE];
    end

    assign m_data  = m_writeM ? {{(BANDWIDTH-WORD_SIZE){1'b0}}, wdata_q}
                              : {BANDWIDTH{1'bz}};
    assign c_ready = (state == RESP);

    always_comb begin
        state_next  = state;
        readm_next  = m_readM;
        writem_next = m_writeM;
        addr_next   = m_address;
        rdata_next  = c_rdata;
        off_next    = off_q;
        wdata_next  = wdata_q;
        cnt_next    = cnt;
        hit_next    = hit_count;
        miss_next   = miss_count;
        fill_en     = 1'b0;
        wr_hit_en   = 1'b0;

        unique case (state)
            IDLE: begin
                if (c_write) begin
                    state_next  = WRITE;
                    writem_next = 1'b1;
                    addr_next   = c_address;
                    off_next    = req_off;
                    wdata_next  = c_wdata;
                end else if (c_read) begin
                    off_next = req_off;
                    if (req_hit) begin
                        state_next = RESP;
                        rdata_next = line_data[req_idx][req_off];
                        if (hit_count != '1) hit_next = hit_count + 16'd1;
                    end else begin
                        state_next = FILL;
                        readm_next = 1'b1;
                        addr_next  = {c_address[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                        cnt_next   = CNT_W'(1);
                        if (miss_count != '1) miss_next = miss_count + 16'd1;
                    end
                end
            end
            FILL: begin
                // The block is captured at the edge closing the last cycle
                // that m_readM is held.
                if (cnt == CNT_W'(MEM_LATENCY)) begin
                    fill_en    = 1'b1;
                    readm_next = 1'b0;
                    rdata_next = bus_word[off_q];
                    state_next = RESP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                wr_hit_en   = cur_hit;
                writem_next = 1'b0;
                state_next  = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            m_readM    <= 1'b0;
            m_writeM   <= 1'b0;
            m_address  <= '0;
            c_rdata    <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            line_valid <= '0;
        end else begin
            state      <= state_next;
            m_readM    <= readm_next;
            m_writeM   <= writem_next;
            m_address  <= addr_next;
            c_rdata    <= rdata_next;
            off_q      <= off_next;
            wdata_q    <= wdata_next;
            cnt        <= cnt_next;
            hit_count  <= hit_next;
            miss_count <= miss_next;
            if (fill_en) line_valid[cur_idx] <= 1'b1;
        end
    end

    // Data and tags are only meaningful behind a valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_tag[cur_idx] <= cur_tag;
            for (int unsigned k = 0; k < WORDS; k++) begin
                line_data[cur_idx][k] <= bus_word[k];
            end
        end else if (wr_hit_en) begin
            line_data[cur_idx][off_q] <= wdata_q;
        end
    end

endmodule
